// File: rtl/dcache_store_coalescer.sv
// In-order store buffer in front of the L1 data cache store port, with flush drain.
// Define DCACHE_SC_COALESCE_EN to merge back-to-back stores to the same doubleword.
module dcache_store_coalescer #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 56,
  parameter int DATA_WIDTH = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    st_valid_i,
  output logic                    st_ready_o,
  input  logic [ADDR_WIDTH-1:0]   st_addr_i,
  input  logic [DATA_WIDTH-1:0]   st_data_i,
  input  logic [DATA_WIDTH/8-1:0] st_be_i,
  output logic                    dc_req_o,
  input  logic                    dc_gnt_i,
  output logic [ADDR_WIDTH-1:0]   dc_addr_o,
  output logic [DATA_WIDTH-1:0]   dc_wdata_o,
  output logic [DATA_WIDTH/8-1:0] dc_be_o,
  input  logic                    flush_i,
  output logic                    flush_ack_o,
  output logic                    empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int TAG_W = ADDR_WIDTH - 3;

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    FL_IDLE,
    FL_DRAIN,
    FL_DONE
  } flush_state_e;

  logic [TAG_W-1:0]      tag_q  [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [BE_W-1:0]       be_q   [DEPTH];

  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q;
  flush_state_e     fl_state_q, fl_state_d;

  logic [TAG_W-1:0] st_tag;
  logic [2:0]       unused_addr_lsb;
  logic             merge_hit;
  logic             push;
  logic             pop;

  assign st_tag          = st_addr_i[ADDR_WIDTH-1:3];
  assign unused_addr_lsb = st_addr_i[2:0];

`ifdef DCACHE_SC_COALESCE_EN
  logic [PTR_W-1:0] young_ptr;
  assign young_ptr = tail_q - PTR_ONE;
  // count >= 2 guarantees the youngest entry is not the head being offered.
  assign merge_hit = st_valid_i && !flush_i && (count_q >= CNT_W'(2)) &&
                     (tag_q[young_ptr] == st_tag);
`else
  assign merge_hit = 1'b0;
`endif

  // A full buffer does not count a same-cycle pop as a free slot.
  assign st_ready_o = !flush_i && (fl_state_q != FL_DRAIN) &&
                      ((count_q < CNT_FULL) || merge_hit);

  assign push = st_valid_i && st_ready_o && !merge_hit && (st_be_i != '0);
  assign pop  = dc_req_o && dc_gnt_i;

  assign dc_req_o   = (count_q != '0);
  assign empty_o    = (count_q == '0);
  assign dc_addr_o  = {tag_q[head_q], 3'b000};
  assign dc_wdata_o = data_q[head_q];
  assign dc_be_o    = be_q[head_q];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      fl_state_q <= FL_IDLE;
    end else begin
      fl_state_q <= fl_state_d;
      if (push) tail_q <= tail_q + PTR_ONE;
      if (pop)  head_q <= head_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: entry storage has no reset; count_q == 0 already marks every slot
  // invalid, so discarded entries are never observed.
  always_ff @(posedge clk_i) begin
    if (push) begin
      tag_q[tail_q]  <= st_tag;
      data_q[tail_q] <= st_data_i;
      be_q[tail_q]   <= st_be_i;
    end
`ifdef DCACHE_SC_COALESCE_EN
    if (merge_hit && st_ready_o) begin
      for (int b = 0; b < BE_W; b++) begin
        if (st_be_i[b]) begin
          data_q[young_ptr][b*8 +: 8] <= st_data_i[b*8 +: 8];
          be_q[young_ptr][b]          <= 1'b1;
        end
      end
    end
`endif
  end

  // NOTE: defaults first so no path through the case leaves an output
  // unassigned, which would infer a latch.
  always_comb begin
    fl_state_d  = fl_state_q;
    flush_ack_o = 1'b0;
    case (fl_state_q)
      FL_IDLE:  if (flush_i) fl_state_d = FL_DRAIN;
      FL_DRAIN: begin
        if (count_q == '0) begin
          flush_ack_o = 1'b1;
          fl_state_d  = FL_DONE;
        end
      end
      FL_DONE:  if (!flush_i) fl_state_d = FL_IDLE;
      default:  fl_state_d = FL_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_store_coalescer.sv
// Self-checking bench for dcache_store_coalescer: directed scenarios plus random
// traffic compared against a queue-based model of the store buffer.
module tb_dcache_store_coalescer;

  localparam int DEPTH = 4;

`ifdef DCACHE_SC_COALESCE_EN
  localparam bit COALESCE = 1'b1;
`else
  localparam bit COALESCE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        st_valid;
  logic        st_ready;
  logic [55:0] st_addr;
  logic [63:0] st_data;
  logic [7:0]  st_be;
  logic        dc_req;
  logic        dc_gnt;
  logic [55:0] dc_addr;
  logic [63:0] dc_wdata;
  logic [7:0]  dc_be;
  logic        flush;
  logic        flush_ack;
  logic        empty;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [55:0] addr;
    logic [63:0] data;
    logic [7:0]  be;
  } ent_t;

  ent_t q[$];
  bit   m_flush_prev = 1'b0;
  bit   m_acked = 1'b0;

  dcache_store_coalescer #(
    .DEPTH(DEPTH), .ADDR_WIDTH(56), .DATA_WIDTH(64)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .st_valid_i (st_valid),
    .st_ready_o (st_ready),
    .st_addr_i  (st_addr),
    .st_data_i  (st_data),
    .st_be_i    (st_be),
    .dc_req_o   (dc_req),
    .dc_gnt_i   (dc_gnt),
    .dc_addr_o  (dc_addr),
    .dc_wdata_o (dc_wdata),
    .dc_be_o    (dc_be),
    .flush_i    (flush),
    .flush_ack_o(flush_ack),
    .empty_o    (empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, then
  // advance the model to the state after the coming rising edge.
  task automatic step(input bit v, input logic [55:0] a, input logic [63:0] d,
                      input logic [7:0] be, input bit g, input bit f, output bit ack);
    int n;
    bit mh, rdy;
    logic [55:0] dw;
    @(negedge clk);
    st_valid = v; st_addr = a; st_data = d; st_be = be; dc_gnt = g; flush = f;
    #1;
    n   = q.size();
    dw  = {a[55:3], 3'b000};
    mh  = COALESCE && v && !f && (n >= 2) && (q[n-1].addr == dw);
    rdy = !f && ((n < DEPTH) || mh);
    ack = f && m_flush_prev && !m_acked && (n == 0);
    check("st_ready", 64'(st_ready), 64'(rdy));
    check("dc_req", 64'(dc_req), 64'(n != 0));
    check("empty", 64'(empty), 64'(n == 0));
    check("flush_ack", 64'(flush_ack), 64'(ack));
    if (n != 0) begin
      check("dc_addr", 64'(dc_addr), 64'(q[0].addr));
      check("dc_wdata", dc_wdata, q[0].data);
      check("dc_be", 64'(dc_be), 64'(q[0].be));
    end
    if (v && rdy) begin
      if (mh) begin
        for (int b = 0; b < 8; b++) begin
          if (be[b]) begin
            q[n-1].data[b*8 +: 8] = d[b*8 +: 8];
            q[n-1].be[b] = 1'b1;
          end
        end
      end else if (be != 8'h00) begin
        q.push_back('{addr: dw, data: d, be: be});
      end
    end
    if (g && n != 0) void'(q.pop_front());
    if (ack) m_acked = 1'b1;
    if (!f) m_acked = 1'b0;
    m_flush_prev = f;
  endtask

  task automatic idle(input bit g, input bit f, output bit ack);
    step(1'b0, 56'h0, 64'h0, 8'h00, g, f, ack);
  endtask

  initial begin
    bit ack;
    bit fl;
    int fl_hold;
    int acks;
    logic [55:0] ra;
    logic [7:0]  rbe;

    rst_ni = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_be = '0;
    dc_gnt = 1'b0; flush = 1'b0;
    #3;
    check("rst_req", 64'(dc_req), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_ack", 64'(flush_ack), 64'd0);
    @(negedge clk); rst_ni = 1'b1;

    // Single store reaches the cache one cycle later, then retires.
    step(1'b1, 56'h1000, 64'h11, 8'h01, 1'b0, 1'b0, ack);
    idle(1'b1, 1'b0, ack);
    idle(1'b0, 1'b0, ack);

    // Back-to-back stores to 0x3000 merge into one entry when coalescing.
    step(1'b1, 56'h2000, 64'h0000_0000_aabb_ccdd, 8'h0F, 1'b0, 1'b0, ack);
    step(1'b1, 56'h3000, 64'h0000_0000_1122_3344, 8'h0F, 1'b0, 1'b0, ack);
    step(1'b1, 56'h3004, 64'h5566_7788_0000_0000, 8'hF0, 1'b0, 1'b0, ack);
    idle(1'b0, 1'b0, ack);
    check("entries_after_merge", 64'(q.size()), COALESCE ? 64'd2 : 64'd3);
    repeat (4) idle(1'b1, 1'b0, ack);

    // Fill to DEPTH; a store in the same cycle as a grant must wait.
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, 56'h8000 + 56'(i) * 56'h40, 64'(i + 1), 8'hFF, 1'b0, 1'b0, ack);
    step(1'b1, 56'h9000, 64'h55, 8'hFF, 1'b1, 1'b0, ack);
    step(1'b1, 56'h9000, 64'h55, 8'hFF, 1'b0, 1'b0, ack);
    repeat (5) idle(1'b1, 1'b0, ack);

    // Zero byte-enable store is accepted and dropped.
    step(1'b1, 56'hA000, 64'hdead, 8'h00, 1'b0, 1'b0, ack);
    idle(1'b0, 1'b0, ack);

    // Flush drain with grant every other cycle and stores still offered.
    for (int i = 0; i < 3; i++)
      step(1'b1, 56'hB000 + 56'(i) * 56'h8, 64'(i + 7), 8'h3C, 1'b0, 1'b0, ack);
    acks = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 56'hC000, 64'h99, 8'hFF, 1'(i % 2), 1'b1, ack);
      if (ack) acks++;
    end
    check("flush_ack_count", 64'(acks), 64'd1);
    idle(1'b0, 1'b0, ack);

    // Flush on an empty buffer acknowledges the cycle after it rises.
    idle(1'b0, 1'b1, ack);
    idle(1'b0, 1'b1, ack);
    idle(1'b0, 1'b0, ack);

    // Asynchronous reset with entries pending discards them immediately.
    for (int i = 0; i < 3; i++)
      step(1'b1, 56'hD000 + 56'(i) * 56'h8, 64'(i), 8'hFF, 1'b0, 1'b0, ack);
    @(negedge clk);
    st_valid = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    check("midrst_req", 64'(dc_req), 64'd0);
    check("midrst_empty", 64'(empty), 64'd1);
    q.delete();
    m_flush_prev = 1'b0;
    m_acked = 1'b0;
    @(negedge clk); rst_ni = 1'b1;
    idle(1'b0, 1'b0, ack);
    idle(1'b1, 1'b0, ack);

    // Random traffic over a few doublewords to exercise merges and wrap.
    fl = 1'b0;
    fl_hold = 0;
    for (int i = 0; i < 400; i++) begin
      ra  = 56'h4000 + 56'($urandom_range(0, 3)) * 56'h8 + 56'($urandom_range(0, 7));
      rbe = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
      if (!fl && $urandom_range(0, 29) == 0) fl = 1'b1;
      step(1'($urandom_range(0, 3) != 0), ra, {$urandom, $urandom}, rbe,
           1'($urandom_range(0, 2) == 0), fl, ack);
      if (ack) fl_hold = $urandom_range(1, 3);
      else if (fl_hold > 0) begin
        fl_hold--;
        if (fl_hold == 0) fl = 1'b0;
      end
    end
    repeat (8) idle(1'b1, 1'b0, ack);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dcache_store_coalescer.md
Name: dcache_store_coalescer

Overview:
- Upstream stage for the store request port of the non-blocking L1 data cache.
- Buffers committed stores in a small in-order FIFO and merges back-to-back stores to the same 64-bit doubleword into one entry.
- Issues entries to the cache controller's store port with a req/gnt handshake; the surrounding wrapper packs the outputs into the cache request struct.
- Supports a flush drain, so the cache flush is only acknowledged once no store is pending.

Parameters:
- DEPTH, 4, number of buffered doubleword entries; power of two, at least 2.
- ADDR_WIDTH, 56, physical address width.
- DATA_WIDTH, 64, data width; byte-enable width is DATA_WIDTH/8.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- st_valid_i  in  1  committed store valid
- st_ready_o  out  1  store accepted this cycle when high together with st_valid_i
- st_addr_i  in  ADDR_WIDTH  store byte address; bits [2:0] are ignored
- st_data_i  in  DATA_WIDTH  store data, doubleword-aligned lanes
- st_be_i  in  DATA_WIDTH/8  byte enables
- dc_req_o  out  1  request to the cache store port
- dc_gnt_i  in  1  cache grant; the head entry retires on req&&gnt
- dc_addr_o  out  ADDR_WIDTH  head entry doubleword address; [2:0] = 0
- dc_wdata_o  out  DATA_WIDTH  head entry merged data
- dc_be_o  out  DATA_WIDTH/8  head entry merged byte enables
- flush_i  in  1  level request to drain, held until acknowledged
- flush_ack_o  out  1  single-cycle pulse when drained
- empty_o  out  1  no entries held

Behaviour:
- Reset values: count=0, head=tail=0, dc_req_o=0, flush_ack_o=0, empty_o=1.
- Reset may assert mid-operation; all entries are then discarded.
- Storage: DEPTH entries of {addr[ADDR_WIDTH-1:3], data, be}. Head and tail pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- Output:
  - dc_req_o = (count != 0); dc_addr_o, dc_wdata_o and dc_be_o come from the head entry.
  - Outputs stay stable while dc_req_o=1 and dc_gnt_i=0.
  - On dc_req_o && dc_gnt_i, head increments and count decrements.
- Merge hit: all of the following hold:
  - st_valid_i=1 and count >= 2;
  - youngest entry (tail-1) address == st_addr_i[ADDR_WIDTH-1:3];
  - youngest entry is not the head;
  - flush_i=0.
  - The head is never modified, because it is being offered.
- On merge, for each byte b with st_be_i[b]=1: entry.data byte b <= st_data_i byte b and entry.be[b] <= 1. Newer bytes overwrite older ones. count and tail are unchanged.
- Push: st_valid_i && st_ready_o && !merge hit && st_be_i != 0 writes entry[tail], then tail increments and count increments.
- A store with st_be_i == 0 is accepted when ready and then dropped; state is unchanged.
- st_ready_o = !flush_i && (count < DEPTH || merge hit).
  - When full, a same-cycle pop does not free a slot for the incoming store; this keeps the path registered.
- Simultaneous push and pop: count is unchanged, and both pointers advance.
- Simultaneous merge and pop: this is legal, since the merge target is never the head.
- Store latency: a push into an empty buffer drives dc_req_o the next cycle. Minimum store-to-cache latency is 1 cycle.
- empty_o = (count == 0), combinational from the registers.
- Flush state machine:
  - IDLE: flush_i=1 -> DRAIN.
  - DRAIN: no stores accepted; keeps issuing. When count == 0, pulse flush_ack_o for 1 cycle -> DONE.
  - DONE: wait for flush_i=0 -> IDLE. No repeat ack while flush_i stays high.
  - flush_i=1 with an empty buffer: ack on the cycle after flush_i rises.

Optional Feature:
- Macro DCACHE_SC_COALESCE_EN.
- Defined: merge behaviour exactly as above.
- Undefined: merge hit is forced to 0, so the block is a pure in-order FIFO.
  - Every accepted store with nonzero be occupies its own entry.
  - st_ready_o = !flush_i && count < DEPTH.

Test Plan:
- Reset, then one store (addr 0x1000, data 0x11, be 0x01) -> dc_req_o=1 next cycle with dc_addr_o=0x1000 and dc_be_o=0x01; gnt -> empty_o=1 the following cycle.
- With dc_gnt_i=0, stores in order: 0x2000 be 0x0F, then 0x3000 be 0x0F, then 0x3004 be 0xF0 -> count=2; the second entry has be 0xFF and merged data. With the macro undefined -> count=3.
- Four stores to distinct doublewords with dc_gnt_i=0 -> st_ready_o=0. A fifth store at the same cycle as a grant -> not accepted that cycle, accepted the next.
- A store with be 0x00 and st_valid_i=1 -> st_ready_o=1, count unchanged, no dc_req_o.
- 3 entries queued, flush_i=1, gnt every other cycle -> st_ready_o=0 throughout; flush_ack_o pulses exactly once, one cycle after count reaches 0; no second pulse while flush_i is held.
- rst_ni asserted with 3 entries pending -> dc_req_o=0 and empty_o=1 immediately; no stale request after reset is released.
